// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core load/store path
// (port 0) and the program loader / DMA (port 1). Round-robin arbitration
// with a bounded burst lock, zero-latency grants, and one-cycle-late read
// return steered to whichever port issued the read.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int MAX_LOCK = 8,
    parameter bit P0_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p0_req,
    input  logic          p0_lock,
    input  logic [3:0]    p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    input  logic          p1_req,
    input  logic          p1_lock,
    input  logic [3:0]    p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [31:0]   rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam logic [7:0] MAX_LOCK_V = MAX_LOCK[7:0];

    logic [1:0]    state_reg, state_next;
    logic          last_reg, last_next;
    logic [7:0]    lock_cnt_reg, lock_cnt_next;
    logic          rd_tag_valid_reg, rd_tag_valid_next;
    logic          rd_tag_port_reg, rd_tag_port_next;

    logic [1:0]    gnt;
    logic          gnt_port;
    logic          lock_below;
    logic          sel_lock;
    logic [3:0]    sel_we;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [1:0]    rvalid;

    assign lock_below = (lock_cnt_reg < MAX_LOCK_V);
    // Index of the winner; only meaningful when some grant is active.
    assign gnt_port   = gnt[1];

    // Arbitration: honour the lock owner until its budget runs out while the
    // other port waits, then fall back to round-robin on the last winner.
    always_comb begin
        gnt = 2'b00;
        if (state_reg == OWN0 && p0_req && (lock_below || !p1_req)) begin
            gnt = 2'b01;
        end else if (state_reg == OWN1 && p1_req && (lock_below || !p0_req)) begin
            gnt = 2'b10;
        end else if (p0_req && !p1_req) begin
            gnt = 2'b01;
        end else if (p1_req && !p0_req) begin
            gnt = 2'b10;
        end else if (p0_req && p1_req) begin
            gnt = last_reg ? 2'b01 : 2'b10;
        end
        if (!reset_n) begin
            gnt = 2'b00;
        end
    end

    // Select the winning port's request fields; zero when nobody wins.
    always_comb begin
        sel_lock  = 1'b0;
        sel_we    = 4'h0;
        sel_addr  = '0;
        sel_wdata = 32'h0;
        if (gnt[0]) begin
            sel_lock  = p0_lock;
            sel_we    = p0_we;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end else if (gnt[1]) begin
            sel_lock  = p1_lock;
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    // Next-state for lock ownership, fairness pointer and read tag.
    always_comb begin
        state_next        = IDLE;
        lock_cnt_next     = 8'd0;
        last_next         = last_reg;
        rd_tag_valid_next = 1'b0;
        rd_tag_port_next  = rd_tag_port_reg;
        if (|gnt) begin
            last_next         = gnt_port;
            rd_tag_valid_next = (sel_we == 4'h0);
            rd_tag_port_next  = gnt_port;
            if (sel_lock) begin
                state_next = gnt_port ? OWN1 : OWN0;
                if (state_reg == state_next) begin
                    lock_cnt_next = (lock_cnt_reg == 8'hFF) ? 8'hFF : lock_cnt_reg + 8'd1;
                end else begin
                    lock_cnt_next = 8'd1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            last_reg         <= P0_FIRST;
            lock_cnt_reg     <= 8'd0;
            rd_tag_valid_reg <= 1'b0;
            rd_tag_port_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            last_reg         <= last_next;
            lock_cnt_reg     <= lock_cnt_next;
            rd_tag_valid_reg <= rd_tag_valid_next;
            rd_tag_port_reg  <= rd_tag_port_next;
        end
    end

    // Read return: the tagged port sees rvalid the cycle after its read.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
        assign rvalid[gi] = reset_n && rd_tag_valid_reg && (rd_tag_port_reg == 1'(gi));
    end

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rvalid[0];
    assign p1_rvalid = rvalid[1];
    assign rdata     = mem_rdata;

    // Word-aligned memory port; misaligned low bits are simply dropped.
    assign mem_en    = |gnt;
    assign mem_we    = sel_we;
    assign mem_addr  = sel_addr & ~AW'(3);
    assign mem_wdata = sel_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: per-cycle stimulus with hand-derived expected
// grants; reads are pushed to a scoreboard at grant time and popped when the
// one-cycle-late rvalid is due.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_lock, p1_req, p1_lock;
    logic [3:0]  p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // staged stimulus, applied on the falling edge by step()
    logic        s_rst_n = 1'b0;
    logic        s_p0_req = 1'b0, s_p0_lock = 1'b0, s_p1_req = 1'b0, s_p1_lock = 1'b0;
    logic [3:0]  s_p0_we = 4'h0, s_p1_we = 4'h0;
    logic [31:0] s_p0_addr = 32'h0, s_p1_addr = 32'h0, s_p0_wdata = 32'h0, s_p1_wdata = 32'h0;
    logic [31:0] s_rdata = 32'h0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int sb_port[$];
    int sb_cyc[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .MAX_LOCK(8), .P0_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    // One clock cycle: apply staged inputs, then check outputs against the
    // expected grant and the scoreboard.
    task automatic step(input logic [1:0] exp_gnt);
        logic [1:0]  exp_rv;
        logic [3:0]  e_we;
        logic [31:0] e_addr, e_wd;
        int          p;
        @(negedge clk);
        reset_n   = s_rst_n;
        p0_req    = s_p0_req;  p0_lock = s_p0_lock; p0_we = s_p0_we;
        p0_addr   = s_p0_addr; p0_wdata = s_p0_wdata;
        p1_req    = s_p1_req;  p1_lock = s_p1_lock; p1_we = s_p1_we;
        p1_addr   = s_p1_addr; p1_wdata = s_p1_wdata;
        mem_rdata = s_rdata;
        #1;
        cyc++;
        if (!s_rst_n) begin
            sb_port.delete();
            sb_cyc.delete();
        end
        exp_rv = 2'b00;
        if (sb_port.size() > 0 && sb_cyc[0] == cyc - 1) begin
            p = sb_port.pop_front();
            void'(sb_cyc.pop_front());
            exp_rv[p] = 1'b1;
            chk("rdata", rdata, s_rdata);
        end
        chk("rvalid", 32'({p1_rvalid, p0_rvalid}), 32'(exp_rv));
        chk("gnt", 32'({p1_gnt, p0_gnt}), 32'(exp_gnt));
        e_we = 4'h0; e_addr = 32'h0; e_wd = 32'h0;
        if (exp_gnt == 2'b01) begin
            e_we = s_p0_we; e_addr = s_p0_addr & 32'hFFFF_FFFC; e_wd = s_p0_wdata;
            if (s_p0_we == 4'h0) begin sb_port.push_back(0); sb_cyc.push_back(cyc); end
        end else if (exp_gnt == 2'b10) begin
            e_we = s_p1_we; e_addr = s_p1_addr & 32'hFFFF_FFFC; e_wd = s_p1_wdata;
            if (s_p1_we == 4'h0) begin sb_port.push_back(1); sb_cyc.push_back(cyc); end
        end
        chk("mem_en", 32'(mem_en), 32'(exp_gnt != 2'b00));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        $display("cyc %0d rst_n=%0b req=%0b%0b gnt=%0b%0b rv=%0b%0b addr=0x%08h we=%h",
                 cyc, reset_n, p1_req, p0_req, p1_gnt, p0_gnt, p1_rvalid, p0_rvalid,
                 mem_addr, mem_we);
    endtask

    task automatic idle_inputs();
        s_p0_req = 1'b0; s_p0_lock = 1'b0; s_p0_we = 4'h0;
        s_p1_req = 1'b0; s_p1_lock = 1'b0; s_p1_we = 4'h0;
    endtask

    initial begin
        logic [12:0] sched;
        int          n1;

        // Reset with both ports requesting: everything held low.
        idle_inputs();
        s_p0_req = 1'b1; s_p1_req = 1'b1;
        s_rst_n = 1'b0;
        step(2'b00);
        step(2'b00);

        // Contended reads right out of reset alternate starting with port 0.
        s_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_p0_addr = 32'h40 + 32'(i * 4);
            s_p1_addr = 32'h80 + 32'(i * 4);
            s_rdata   = $urandom;
            step((i % 2 == 0) ? 2'b01 : 2'b10);
        end
        idle_inputs();
        s_rdata = $urandom;
        step(2'b00);

        // Port 0 single read of 0x10; data returns next cycle.
        s_p0_req = 1'b1; s_p0_addr = 32'h10; s_rdata = $urandom;
        step(2'b01);
        idle_inputs();
        s_rdata = 32'hDEAD_BEEF;
        step(2'b00);

        // Locked port-1 burst against a constantly requesting port 0.
        sched = 13'b1_1110_1111_1111;
        n1 = 0;
        s_p0_req = 1'b1; s_p0_addr = 32'h200; s_p0_we = 4'h0;
        s_p1_req = 1'b1; s_p1_lock = 1'b1; s_p1_we = 4'hF;
        for (int i = 0; i < 13; i++) begin
            s_p1_addr  = 32'h100 + 32'(n1 * 4);
            s_p1_wdata = 32'hA500_0000 + 32'(n1);
            s_rdata    = $urandom;
            step(sched[i] ? 2'b10 : 2'b01);
            if (sched[i]) n1++;
        end
        s_p1_req = 1'b0; s_p1_lock = 1'b0;
        s_rdata = $urandom;
        step(2'b01);
        idle_inputs();
        s_rdata = $urandom;
        step(2'b00);

        // Locked port-1 burst with port 0 idle: no break past MAX_LOCK.
        s_p1_req = 1'b1; s_p1_lock = 1'b1; s_p1_we = 4'hF;
        for (int i = 0; i < 12; i++) begin
            s_p1_addr  = 32'h100 + 32'(i * 4);
            s_p1_wdata = 32'h5A00_0000 + 32'(i);
            step(2'b10);
        end
        // Count is past the limit, so a newly waiting port 0 wins at once.
        s_p0_req = 1'b1; s_p0_addr = 32'h300; s_rdata = $urandom;
        step(2'b01);
        idle_inputs();
        s_rdata = $urandom;
        step(2'b00);

        // Misaligned byte store: low bits dropped, no read return.
        s_p0_req = 1'b1; s_p0_we = 4'b0010; s_p0_addr = 32'h7; s_p0_wdata = 32'h0000_AB00;
        step(2'b01);
        idle_inputs();
        s_rdata = $urandom;
        step(2'b00);

        // Lock without request is ignored.
        s_p0_lock = 1'b1; s_p1_req = 1'b1; s_p1_addr = 32'h20;
        step(2'b10);
        idle_inputs();
        s_rdata = $urandom;
        step(2'b00);

        // Read granted, then reset: the pending return is suppressed and the
        // first contended cycle afterwards goes to port 0 again.
        s_p0_req = 1'b1; s_p0_lock = 1'b1; s_p0_addr = 32'h44;
        step(2'b01);
        idle_inputs();
        s_rst_n = 1'b0; s_rdata = $urandom;
        step(2'b00);
        s_rst_n = 1'b1;
        s_p0_req = 1'b1; s_p1_req = 1'b1; s_p0_addr = 32'h48; s_p1_addr = 32'h4C;
        s_rdata = $urandom;
        step(2'b01);
        idle_inputs();
        s_rdata = $urandom;
        step(2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
